// File: rtl/dmem_arbiter.sv
// Two-master arbiter and access sequencer for the shared data-memory port.
// Latches the winning request into a one-cycle ACCESS slot and returns registered load data.
module dmem_arbiter #(
  parameter bit PRIORITY_MODE = 1'b0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [1:0]  i_m0_size,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [1:0]  i_m1_size,
  output logic        o_m0_gnt,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_rvalid,
  output logic        o_m0_err,
  output logic        o_m1_gnt,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_rvalid,
  output logic        o_m1_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_writedata,
  output logic [1:0]  o_mem_size,
  output logic        o_mem_re,
  output logic        o_mem_we,
  input  logic [31:0] i_mem_readdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 2;
  localparam logic [SW-1:0] SIZE_WORD = 2'b11;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_owner;
  logic            r_last;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [SW-1:0]   r_size;
  logic            r_reject;
  logic [DW-1:0]   r_rdata0;
  logic [DW-1:0]   r_rdata1;
  logic            r_rvalid0;
  logic            r_rvalid1;
  logic            r_err0;
  logic            r_err1;

  logic            w_access;
  logic            w_elig0;
  logic            w_elig1;
  logic            w_any;
  logic            w_win;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic [SW-1:0]   w_sel_size;

  // The current owner still holds req during its own ACCESS cycle, so it is masked out.
  always_comb begin
    w_access    = (r_state == S_ACCESS);
    w_elig0     = i_m0_req && !(w_access && !r_owner);
    w_elig1     = i_m1_req && !(w_access && r_owner);
    w_any       = w_elig0 || w_elig1;
    if (w_elig0 && w_elig1) begin
      w_win = PRIORITY_MODE ? 1'b0 : !r_last;
    end else begin
      w_win = !w_elig0;
    end
    w_sel_we    = w_win ? i_m1_we    : i_m0_we;
    w_sel_addr  = w_win ? i_m1_addr  : i_m0_addr;
    w_sel_wdata = w_win ? i_m1_wdata : i_m0_wdata;
    w_sel_size  = w_win ? i_m1_size  : i_m0_size;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_size    <= '0;
      r_reject  <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      // Load completion: capture data (or zero for a rejected load) for the owner.
      if (w_access && !r_we) begin
        if (r_owner) begin
          r_rdata1  <= r_reject ? '0 : i_mem_readdata;
          r_rvalid1 <= 1'b1;
          r_err1    <= r_reject;
        end else begin
          r_rdata0  <= r_reject ? '0 : i_mem_readdata;
          r_rvalid0 <= 1'b1;
          r_err0    <= r_reject;
        end
      end
      if (w_any) begin
        r_state  <= S_ACCESS;
        r_owner  <= w_win;
        r_last   <= w_win;
        r_we     <= w_sel_we;
        r_addr   <= w_sel_addr;
        r_wdata  <= w_sel_wdata;
        r_size   <= w_sel_size;
        r_reject <= !w_sel_we && (w_sel_size != SIZE_WORD);
      end else begin
        r_state  <= S_IDLE;
      end
    end
  end

  assign o_m0_gnt        = w_access && !r_owner;
  assign o_m1_gnt        = w_access && r_owner;
  assign o_mem_addr      = r_addr;
  assign o_mem_writedata = r_wdata;
  assign o_mem_size      = r_size;
  assign o_mem_we        = w_access && r_we;
  assign o_mem_re        = w_access && !r_we && !r_reject;
  assign o_m0_rdata      = r_rdata0;
  assign o_m1_rdata      = r_rdata1;
  assign o_m0_rvalid     = r_rvalid0;
  assign o_m1_rvalid     = r_rvalid1;
  assign o_m0_err        = r_err0;
  assign o_m1_err        = r_err1;

endmodule
